shift_reg_burst: RTL

//  Parametrised universal shift register: parallel load, single-step shifts and

---
 rtl/shift_reg_burst.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_reg_burst.sv
// Universal shift register with parallel load, single-step shifts and
// counter-driven burst shifts (fill / rotate / arithmetic) with busy/done handshake.
module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             w,
  input  logic [WIDTH-1:0] din,
  input  logic             shr,
  input  logic             shl,
  input  logic             shift_bit,
  input  logic             start,
  input  logic [CNT_W-1:0] n_bits,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] dout_r, dout_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             dir_r, dir_s;
  logic [1:0]       mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] n_clamp_s;

  // One burst step; mode 2'b11 behaves as fill, arithmetic-left is a plain 0-fill shift.
  function automatic logic [WIDTH-1:0] burst_step(
    input logic [WIDTH-1:0] data,
    input logic             left,
    input logic [1:0]       md,
    input logic             fill_bit
  );
    logic [WIDTH-1:0] res;
    res = data;
    if (left) begin
      case (md)
        2'b01:   res = {data[WIDTH-2:0], data[WIDTH-1]};
        2'b10:   res = {data[WIDTH-2:0], 1'b0};
        default: res = {data[WIDTH-2:0], fill_bit};
      endcase
    end else begin
      case (md)
        2'b01:   res = {data[0], data[WIDTH-1:1]};
        2'b10:   res = {data[WIDTH-1], data[WIDTH-1:1]};
        default: res = {fill_bit, data[WIDTH-1:1]};
      endcase
    end
    return res;
  endfunction

  assign n_clamp_s = (n_bits > MAX_CNT) ? MAX_CNT : n_bits;

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_s = state_r;
    dout_s  = dout_r;
    cnt_s   = cnt_r;
    dir_s   = dir_r;
    mode_s  = mode_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cl) begin
          dout_s = {WIDTH{1'b0}};
        end else if (w) begin
          dout_s = din;
        end else if (start) begin
          dir_s  = dir;
          mode_s = mode;
          cnt_s  = n_clamp_s;
          if (n_clamp_s == {CNT_W{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_SHIFT;
            busy_s  = 1'b1;
          end
        end else if (shr) begin
          dout_s = {shift_bit, dout_r[WIDTH-1:1]};
        end else if (shl) begin
          dout_s = {dout_r[WIDTH-2:0], shift_bit};
        end else begin
          dout_s = dout_r;
        end
      end
      ST_SHIFT: begin
        if (cl) begin
          // Abort: no done pulse for a cleared burst.
          dout_s  = {WIDTH{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          dout_s = burst_step(dout_r, dir_r, mode_r, shift_bit);
          cnt_s  = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            busy_s = 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      dout_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dout_r  <= dout_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      mode_r  <= mode_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign dout    = dout_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ser_out = dir_r ? dout_r[WIDTH-1] : dout_r[0];

endmodule
